// File: rtl/fetch_align_pkg.sv
// Shared types and constants for the instruction fetch aligner.
package fetch_align_pkg;

  localparam int HW_W = 16;

  typedef enum logic [1:0] {RUN, WAIT, DRAIN} fetch_state_type;

  typedef struct packed {
    logic        fetch_req_ready;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_data;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_ready;
  } fetch_align_in_type;

  typedef struct packed {
    logic        fetch_req_valid;
    logic [31:0] fetch_req_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_compressed;
  } fetch_align_out_type;

  // A halfword whose low two bits are 2'b11 opens a 32-bit instruction.
  function automatic logic is_full(input logic [HW_W-1:0] hw);
    return hw[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_buf.sv
// Three-slot halfword queue: shift out 0/1/2 slots, then append 0/1/2 at the tail.
module fetch_align_buf
  import fetch_align_pkg::*;
(
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic [1:0]        i_shift,
  input  logic [1:0]        i_app_n,
  input  logic [2*HW_W-1:0] i_app_data,
  output logic [HW_W-1:0]   o_slot0,
  output logic [HW_W-1:0]   o_slot1,
  output logic [1:0]        o_hcount
);

  logic [2:0][HW_W-1:0] r_buf, w_buf;
  logic [1:0]           r_hcount, w_hcount, w_base;

  always_comb begin
    unique case (i_shift)
      2'd1:    w_buf = {{HW_W{1'b0}}, r_buf[2], r_buf[1]};
      2'd2:    w_buf = {{(2*HW_W){1'b0}}, r_buf[2]};
      default: w_buf = r_buf;
    endcase
    // Issue only happens at hcount <= 1, so the tail never runs past slot 2.
    w_base = r_hcount - i_shift;
    if (i_app_n != 2'd0) w_buf[w_base] = i_app_data[HW_W-1:0];
    if (i_app_n == 2'd2) w_buf[w_base + 2'd1] = i_app_data[2*HW_W-1:HW_W];
    w_hcount = w_base + i_app_n;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_buf    <= '0;
      r_hcount <= '0;
    end else if (i_clear) begin
      r_buf    <= '0;
      r_hcount <= '0;
    end else begin
      r_buf    <= w_buf;
      r_hcount <= w_hcount;
    end
  end

  assign o_slot0  = r_buf[0];
  assign o_slot1  = r_buf[1];
  assign o_hcount = r_hcount;

endmodule

// File: rtl/fetch_align.sv
// Fetch aligner: word fetches in, one 16/32-bit instruction per handshake out.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_fetch_req_valid,
  output logic [31:0] o_fetch_req_addr,
  input  logic        i_fetch_req_ready,
  input  logic        i_fetch_rsp_valid,
  input  logic [31:0] i_fetch_rsp_data,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr_data,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_compressed
);

  fetch_align_in_type  w_in;
  fetch_align_out_type w_out;

  fetch_state_type r_state, w_state;
  logic [31:0]     r_pc, w_pc, r_faddr, w_faddr;
  logic            r_skip_low, w_skip_low;

  logic [HW_W-1:0] w_slot0, w_slot1;
  logic [1:0]      w_hcount, w_shift, w_app_n;
  logic [31:0]     w_app_data;
  logic            w_full, w_accept, w_consume, w_resp;

  assign w_in = '{fetch_req_ready: i_fetch_req_ready, fetch_rsp_valid: i_fetch_rsp_valid,
                  fetch_rsp_data: i_fetch_rsp_data, flush: i_flush, flush_pc: i_flush_pc,
                  instr_ready: i_instr_ready};

  assign w_full = is_full(w_slot0);

  always_comb begin
    w_out.instr_valid      = (w_hcount >= 2'd2) || (w_hcount == 2'd1 && !w_full);
    w_out.instr_compressed = w_out.instr_valid && !w_full;
    w_out.instr_data       = '0;
    if (w_out.instr_valid)
      w_out.instr_data = w_full ? {w_slot1, w_slot0} : {{HW_W{1'b0}}, w_slot0};
    w_out.instr_pc         = r_pc;
    w_out.fetch_req_valid  = (r_state == RUN) && (w_hcount <= 2'd1) && !w_in.flush && !i_reset;
    w_out.fetch_req_addr   = r_faddr;
  end

  assign w_accept   = w_out.fetch_req_valid && w_in.fetch_req_ready;
  assign w_consume  = w_out.instr_valid && w_in.instr_ready && !w_in.flush;
  assign w_resp     = (r_state == WAIT) && w_in.fetch_rsp_valid && !w_in.flush;
  assign w_shift    = w_consume ? (w_full ? 2'd2 : 2'd1) : 2'd0;
  assign w_app_n    = w_resp ? (r_skip_low ? 2'd1 : 2'd2) : 2'd0;
  assign w_app_data = r_skip_low ? {{HW_W{1'b0}}, w_in.fetch_rsp_data[31:16]} : w_in.fetch_rsp_data;

  fetch_align_buf u_buf (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (w_in.flush),
    .i_shift    (w_shift),
    .i_app_n    (w_app_n),
    .i_app_data (w_app_data),
    .o_slot0    (w_slot0),
    .o_slot1    (w_slot1),
    .o_hcount   (w_hcount)
  );

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_faddr    = r_faddr;
    w_skip_low = r_skip_low;
    if (w_in.flush) begin
      // A response landing in the flush cycle retires the outstanding request.
      w_state    = (r_state != RUN && !w_in.fetch_rsp_valid) ? DRAIN : RUN;
      w_pc       = w_in.flush_pc;
      w_faddr    = {w_in.flush_pc[31:2], 2'b00};
      w_skip_low = w_in.flush_pc[1];
    end else begin
      w_pc = r_pc + {29'd0, w_shift, 1'b0};
      unique case (r_state)
        RUN:   if (w_accept) begin
                 w_state = WAIT;
                 w_faddr = r_faddr + 32'd4;
               end
        WAIT:  if (w_in.fetch_rsp_valid) begin
                 w_state    = RUN;
                 w_skip_low = 1'b0;
               end
        DRAIN: if (w_in.fetch_rsp_valid) w_state = RUN;
        default: w_state = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_faddr    <= {RESET_PC[31:2], 2'b00};
      r_skip_low <= RESET_PC[1];
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_faddr    <= w_faddr;
      r_skip_low <= w_skip_low;
    end
  end

  assign o_fetch_req_valid  = w_out.fetch_req_valid;
  assign o_fetch_req_addr   = w_out.fetch_req_addr;
  assign o_instr_valid      = w_out.instr_valid;
  assign o_instr_data       = w_out.instr_data;
  assign o_instr_pc         = w_out.instr_pc;
  assign o_instr_compressed = w_out.instr_compressed;

endmodule
